// File: rtl/muldiv_seq_pkg.sv
// Shared types for the sequential multiply/divide unit: datapath word,
// RISC-V M funct3 encodings and the controller state enum.
package muldiv_seq_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic is_div_op(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not underflow.
module muldiv_seq_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   part_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  logic [XLEN:0] diff_s;

  // The remainder invariant keeps part_i < 2*divisor, so bit XLEN of the difference is the borrow.
  always_comb begin
    diff_s = part_i - {1'b0, divisor_i};
    qbit_o = ~diff_s[XLEN];
    if (qbit_o) begin
      rem_o = diff_s[XLEN-1:0];
    end else begin
      rem_o = part_i[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M unit: one-cycle multiply, radix-2 restoring divide.
// Owns the FSM, iteration counter, operand registers and sign fix-up.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = $bits(xlen_t)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_WORD = CW'(32);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    return {{(XLEN-32){sgn & v[31]}}, v};
  endfunction

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d, op_in_s;
  logic            word_q, word_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, rem_q, rem_d, result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, done_q;

  logic            sgn_in_s, a_neg_s, b_neg_s, div0_s, ovf_s;
  logic [XLEN-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, dvd_res_s, special_res_s;
  logic            mul_sa_s, mul_sb_s;
  logic [2*XLEN-1:0] mul_ea_s, mul_eb_s, prod_s;
  logic [XLEN-1:0] mul_res_s, q_mag_s, q_fix_s, r_fix_s, div_res_s, step_rem_s;
  logic            step_q_s;

  // Decode the incoming request: word extension, magnitudes and the two no-iteration cases.
  always_comb begin
    op_in_s  = md_op_e'(op);
    sgn_in_s = (op_in_s == OP_DIV) || (op_in_s == OP_REM);
    a_ext_s  = word ? ext32(a[31:0], sgn_in_s) : a;
    b_ext_s  = word ? ext32(b[31:0], sgn_in_s) : b;
    a_neg_s  = sgn_in_s & a_ext_s[XLEN-1];
    b_neg_s  = sgn_in_s & b_ext_s[XLEN-1];
    a_mag_s  = a_neg_s ? -a_ext_s : a_ext_s;
    b_mag_s  = b_neg_s ? -b_ext_s : b_ext_s;
    div0_s   = (b_ext_s == {XLEN{1'b0}});
    ovf_s    = sgn_in_s && (b_ext_s == {XLEN{1'b1}}) &&
               (word ? (a[31:0] == 32'h8000_0000) : (a == MOST_NEG));
    dvd_res_s = word ? ext32(a[31:0], 1'b1) : a;
    if ((op_in_s == OP_REM) || (op_in_s == OP_REMU)) begin
      special_res_s = div0_s ? dvd_res_s : {XLEN{1'b0}};
    end else begin
      special_res_s = div0_s ? {XLEN{1'b1}} : dvd_res_s;
    end
  end

  // Full-width product; sign-extending to 2*XLEN makes one multiplier serve all signedness mixes.
  always_comb begin
    mul_sa_s = (op_q != OP_MULHU);
    mul_sb_s = (op_q == OP_MUL) || (op_q == OP_MULH);
    mul_ea_s = {{XLEN{mul_sa_s & opa_q[XLEN-1]}}, opa_q};
    mul_eb_s = {{XLEN{mul_sb_s & opb_q[XLEN-1]}}, opb_q};
    prod_s   = mul_ea_s * mul_eb_s;
    if (op_q == OP_MUL) begin
      mul_res_s = word_q ? ext32(prod_s[31:0], 1'b1) : prod_s[XLEN-1:0];
    end else begin
      mul_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  muldiv_seq_div_step #(.XLEN(XLEN)) u_div_step (
    .part_i   ({rem_q, opa_q[XLEN-1]}),
    .divisor_i(opb_q),
    .rem_o    (step_rem_s),
    .qbit_o   (step_q_s)
  );

  // Final-iteration result: apply signs to the magnitudes, then narrow for word ops.
  always_comb begin
    q_mag_s = {opa_q[XLEN-2:0], step_q_s};
    q_fix_s = qneg_q ? -q_mag_s : q_mag_s;
    r_fix_s = rneg_q ? -step_rem_s : step_rem_s;
    if ((op_q == OP_REM) || (op_q == OP_REMU)) begin
      div_res_s = word_q ? ext32(r_fix_s[31:0], 1'b1) : r_fix_s;
    end else begin
      div_res_s = word_q ? ext32(q_fix_s[31:0], 1'b1) : q_fix_s;
    end
  end

  // Next-state and datapath-register update; flush overrides everything and preserves result.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          op_d   = op_in_s;
          word_d = word;
          if (is_div_op(op_in_s)) begin
            // Word dividends are left-aligned so the shared MSB shift-out works for 32 steps.
            opa_d  = word ? {a_mag_s[31:0], {(XLEN-32){1'b0}}} : a_mag_s;
            opb_d  = b_mag_s;
            rem_d  = {XLEN{1'b0}};
            qneg_d = a_neg_s ^ b_neg_s;
            rneg_d = a_neg_s;
            cnt_d  = word ? CNT_WORD : CNT_FULL;
            if (div0_s || ovf_s) begin
              result_d = special_res_s;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end else begin
            opa_d   = a;
            opb_d   = b;
            state_d = ST_MUL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        result_d = mul_res_s;
        state_d  = ST_DONE;
      end
      ST_DIV: begin
        rem_d = step_rem_s;
        opa_d = q_mag_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = div_res_s;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end else begin
      result_d = result_d;
    end
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      opa_q    <= {XLEN{1'b0}};
      opb_q    <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      cnt_q    <= {CW{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= {XLEN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      busy_q   <= (state_d == ST_MUL) || (state_d == ST_DIV);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors, randomized ops against
// an arithmetic reference model, and flush/reset/start-ignore scenarios.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        word = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic        busy, done;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] last_res = 64'd0;

  muldiv_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .word(word),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M semantics computed with plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] sx, sy;
    logic [127:0] ux, uy, p;
    logic [31:0] t32, q32, r32;
    logic [63:0] q64, r64;
    int sa, sb;
    int unsigned ua, ub;
    longint la, lb;
    logic sg;
    sx = $signed(x); sy = $signed(y);
    ux = {64'd0, x}; uy = {64'd0, y};
    sg = (o == 3'd4) || (o == 3'd6);
    case (o)
      3'd0: begin
        t32 = x[31:0] * y[31:0];
        q64 = x * y;
        return w ? sx32(t32) : q64;
      end
      3'd1: begin p = sx * sy; return p[127:64]; end
      3'd2: begin p = sx * uy; return p[127:64]; end
      3'd3: begin p = ux * uy; return p[127:64]; end
      default: begin
        if (w) begin
          sa = $signed(x[31:0]); sb = $signed(y[31:0]);
          ua = x[31:0]; ub = y[31:0];
          if (ub == 0) begin q32 = 32'hFFFF_FFFF; r32 = ua; end
          else if (sg && sa == 32'h8000_0000 && sb == -1) begin q32 = ua; r32 = 32'd0; end
          else if (sg) begin q32 = sa / sb; r32 = sa % sb; end
          else begin q32 = ua / ub; r32 = ua % ub; end
          return o[1] ? sx32(r32) : sx32(q32);
        end else begin
          la = $signed(x); lb = $signed(y);
          if (y == 64'd0) begin q64 = 64'hFFFF_FFFF_FFFF_FFFF; r64 = x; end
          else if (sg && x == 64'h8000_0000_0000_0000 && lb == -64'sd1) begin q64 = x; r64 = 64'd0; end
          else if (sg) begin q64 = la / lb; r64 = la % lb; end
          else begin q64 = x / y; r64 = x % y; end
          return o[1] ? r64 : q64;
        end
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic w,
                                     input logic [63:0] x, input logic [63:0] y);
    logic sg;
    sg = (o == 3'd4) || (o == 3'd6);
    if (!o[2]) return 2;
    if (w ? (y[31:0] == 32'd0) : (y == 64'd0)) return 1;
    if (sg && (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                 : (x == 64'h8000_0000_0000_0000 && y == 64'hFFFF_FFFF_FFFF_FFFF))) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return {32'd0, $urandom()};
      5: return 64'($urandom_range(1, 300));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Drive a request for one cycle; returns #1 after the acceptance edge.
  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    op = o; word = w; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count cycles after acceptance until done; lat=0 means the bound expired.
  task automatic wait_done(output int lat, output int busy_cnt, output logic [63:0] res);
    lat = 0; busy_cnt = 0; res = 64'd0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin lat = n; res = result; return; end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({busy, done} !== 2'b00 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [2:0] op; logic w; logic [63:0] a; logic [63:0] b; logic [63:0] exp; int lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    int lat, bc;
    logic [63:0] res;
    v.push_back('{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 2});
    v.push_back('{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 2});
    v.push_back('{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2});
    v.push_back('{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65});
    v.push_back('{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65});
    v.push_back('{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    v.push_back('{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    v.push_back('{3'd4, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    v.push_back('{3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1});
    v.push_back('{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
    v.push_back('{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1});
    v.push_back('{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    v.push_back('{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33});
    foreach (v[i]) begin
      issue(v[i].op, v[i].w, v[i].a, v[i].b);
      wait_done(lat, bc, res);
      n_cmp++;
      if (res !== v[i].exp) begin
        n_bad++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, v[i].exp);
      end
      n_cmp++;
      if (lat !== v[i].lat) begin
        n_bad++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
      end
      n_cmp++;
      if (bc !== v[i].lat - 1 || busy !== 1'b0) begin
        n_bad++; $display("FAIL directed_busy[%0d]: cycles %0d busy_in_done %b expected %0d 0", i, bc, busy, v[i].lat - 1);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || result !== v[i].exp) begin
        n_bad++; $display("FAIL directed_hold[%0d]: done=%b result=%h expected 0 %h", i, done, result, v[i].exp);
      end
      last_res = v[i].exp;
    end
  endtask

  task automatic test_random();
    int lat, bc, elat;
    logic [63:0] res, x, y, exp;
    logic [2:0] o;
    logic w;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      w = (o == 3'd1 || o == 3'd2 || o == 3'd3) ? 1'b0 : 1'($urandom_range(0, 1));
      x = pick(); y = pick();
      exp = ref_model(o, w, x, y);
      elat = ref_latency(o, w, x, y);
      issue(o, w, x, y);
      wait_done(lat, bc, res);
      n_cmp++;
      if (res !== exp || lat !== elat) begin
        n_bad++;
        $display("FAIL random[%0d] op=%0d w=%b a=%h b=%h: got %h lat %0d expected %h lat %0d",
                 i, o, w, x, y, res, lat, exp, elat);
      end
      @(negedge clk);
      last_res = exp;
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [63:0] res;
    issue(3'd0, 1'b0, 64'd6, 64'd7);
    wait_done(lat, bc, res);
    // start asserted during DONE must be ignored
    op = 3'd5; word = 1'b0; a = 64'd1000; b = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd42) begin
      n_bad++; $display("FAIL start_in_done: busy=%b done=%b result=%h expected 0 0 %h", busy, done, result, 64'd42);
    end
    issue(3'd5, 1'b0, 64'd1000, 64'd10);
    repeat (3) @(posedge clk);
    #1;
    op = 3'd0; a = 64'd9; b = 64'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc, res);
    n_cmp++;
    if (res !== 64'd100 || lat !== 61) begin
      n_bad++; $display("FAIL start_in_div: got %h lat %0d expected %h lat 61", res, lat, 64'd100);
    end
    @(negedge clk);
    last_res = 64'd100;
  endtask

  task automatic test_flush();
    int lat, bc, seen;
    logic [63:0] res;
    issue(3'd5, 1'b0, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
      n_bad++; $display("FAIL flush_div: busy=%b done=%b result=%h expected 0 0 %h", busy, done, result, last_res);
    end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL flush_no_done: active cycles %0d expected 0", seen);
    end
    issue(3'd5, 1'b0, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    issue(3'd5, 1'b0, 64'd1000, 64'd9);
    wait_done(lat, bc, res);
    n_cmp++;
    if (res !== 64'd111 || lat !== 65) begin
      n_bad++; $display("FAIL flush_restart: got %h lat %0d expected %h lat 65", res, lat, 64'd111);
    end
    @(negedge clk);
    last_res = 64'd111;
    issue(3'd0, 1'b0, 64'd5, 64'd5);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
        n_bad++; $display("FAIL flush_mul[%0d]: busy=%b done=%b result=%h expected 0 0 %h", i, busy, done, result, last_res);
      end
    end
  endtask

  task automatic test_flush_start();
    op = 3'd0; word = 1'b0; a = 64'd11; b = 64'd11; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
        n_bad++; $display("FAIL flush_start[%0d]: busy=%b done=%b result=%h expected 0 0 %h", i, busy, done, result, last_res);
      end
    end
  endtask

  task automatic test_flush_done();
    int lat, bc;
    logic [63:0] res;
    issue(3'd0, 1'b0, 64'd6, 64'd7);
    wait_done(lat, bc, res);
    flush = 1'b1;
    n_cmp++;
    if (done !== 1'b1 || res !== 64'd42) begin
      n_bad++; $display("FAIL flush_in_done_pulse: done=%b result=%h expected 1 %h", done, res, 64'd42);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd42) begin
      n_bad++; $display("FAIL flush_in_done_after: busy=%b done=%b result=%h expected 0 0 %h", busy, done, result, 64'd42);
    end
    last_res = 64'd42;
  endtask

  task automatic test_async_reset();
    int lat, bc, seen;
    logic [63:0] res;
    issue(3'd5, 1'b0, 64'd100, 64'd7);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
      n_bad++; $display("FAIL async_reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL reset_no_done: active cycles %0d expected 0", seen);
    end
    issue(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    wait_done(lat, bc, res);
    n_cmp++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFF1 || lat !== 2) begin
      n_bad++; $display("FAIL after_reset_mul: got %h lat %0d expected fffffffffffffff1 lat 2", res, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_flush_start();
    test_flush_done();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
